// File: rtl/adc_rx.sv
// adc_rx: stereo serial ADC receiver producing bclk/cs_n and 16-bit sample pairs over valid/ready
//
// Ports:
//   clk_48      in   system clock (48 MHz)
//   reset_n     in   asynchronous active-low reset
//   enable      in   run conversions; looked at in IDLE and at the end of SHIFT
//   sdata_l/r   in   serial data from the ADC, MSB first, asynchronous to clk_48
//   bclk        out  ADC bit clock, CLK_DIV clk_48 cycles per period, 50% duty
//   cs_n        out  ADC chip select, low for the DATA_W-bit shift window
//   left_out    out  last captured left sample (two's complement)
//   right_out   out  last captured right sample (two's complement)
//   out_valid   out  sample pair available
//   out_ready   in   consumer accepts the pair
//   busy        out  high while a frame is running
//   overrun     out  sticky dropped-pair flag     (only with ADC_RX_OVERRUN_EN)
//   overrun_clr in   clears overrun, set wins     (only with ADC_RX_OVERRUN_EN)
//
// Optional feature macro: ADC_RX_OVERRUN_EN
module adc_rx #(
  parameter int DATA_W      = 16,
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BCLKS = 250
) (
  input  logic              clk_48,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sdata_l,
  input  logic              sdata_r,
  output logic              bclk,
  output logic              cs_n,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef ADC_RX_OVERRUN_EN
  ,
  output logic              overrun,
  input  logic              overrun_clr
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BCLKS);

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]        sync_l_q, sync_r_q;
  logic [DATA_W-1:0] shl_q, shl_d, shr_q, shr_d;
  logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
  logic              bclk_q, bclk_d, cs_n_q, cs_n_d, valid_q, valid_d;
  logic              wrap, last, capture, accept;

  always_comb begin
    wrap      = div_cnt_q == DW'(CLK_DIV - 1);
    last      = (state_q == CONV) ? (bit_cnt_q == BW'(FRAME_BCLKS - DATA_W - 1))
                                  : (bit_cnt_q == BW'(DATA_W - 1));
    capture   = (state_q == SHIFT) && wrap && last;
    accept    = !valid_q || out_ready;
    state_d   = (state_q == IDLE) ? (enable ? CONV : IDLE)
              : !(wrap && last)   ? state_q
              : (state_q == CONV) ? SHIFT
              : (enable ? CONV : IDLE);
    div_cnt_d = (state_q == IDLE || wrap) ? '0 : div_cnt_q + DW'(1);
    bit_cnt_d = (state_q == IDLE || (wrap && last)) ? '0
              : wrap ? bit_cnt_q + BW'(1) : bit_cnt_q;
    // Sample at the end of the bclk high phase, just before the falling edge where the ADC moves on.
    shl_d     = (state_q == SHIFT && wrap) ? {shl_q[DATA_W-2:0], sync_l_q[1]} : shl_q;
    shr_d     = (state_q == SHIFT && wrap) ? {shr_q[DATA_W-2:0], sync_r_q[1]} : shr_q;
    // A stalled consumer keeps its pair; the fresh one is dropped.
    left_d    = (capture && accept) ? shl_d : left_q;
    right_d   = (capture && accept) ? shr_d : right_q;
    valid_d   = (capture && accept) ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
    // bclk/cs_n are decoded from next-state values so the registered outputs line up with div_cnt/state.
    bclk_d    = div_cnt_d >= DW'(CLK_DIV / 2);
    cs_n_d    = state_d != SHIFT;
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sync_l_q  <= '0;
      sync_r_q  <= '0;
      shl_q     <= '0;
      shr_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      bclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sync_l_q  <= {sync_l_q[0], sdata_l};
      sync_r_q  <= {sync_r_q[0], sdata_r};
      shl_q     <= shl_d;
      shr_q     <= shr_d;
      left_q    <= left_d;
      right_q   <= right_d;
      bclk_q    <= bclk_d;
      cs_n_q    <= cs_n_d;
      valid_q   <= valid_d;
    end
  end

`ifdef ADC_RX_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb overrun_d = (capture && !accept) ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign bclk      = bclk_q;
  assign cs_n      = cs_n_q;
  assign left_out  = left_q;
  assign right_out = right_q;
  assign out_valid = valid_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_adc_rx.sv
// tb_adc_rx: directed self-checking bench for adc_rx (small frame instance plus a default-parameter instance)
module tb_adc_rx;
  logic clk_48 = 1'b0, reset_n = 1'b0, enable = 1'b0, out_ready = 1'b1, enable_d = 1'b0;
  logic sdata_l = 1'b0, sdata_r = 1'b0;
  logic bclk, cs_n, out_valid, busy, bclk_d, cs_n_d, out_valid_d, busy_d;
  logic [15:0] left_out, right_out, left_d, right_d;
  logic [15:0] tx_l = '0, tx_r = '0, cur_l = '0, cur_r = '0;
  int idx = 0;
  int passed = 0, total = 0;
`ifdef ADC_RX_OVERRUN_EN
  logic overrun, overrun_d, overrun_clr = 1'b0;
`endif

  always #5 clk_48 = ~clk_48;

  adc_rx #(.DATA_W(16), .CLK_DIV(4), .FRAME_BCLKS(20)) dut (
    .clk_48(clk_48), .reset_n(reset_n), .enable(enable), .sdata_l(sdata_l), .sdata_r(sdata_r),
    .bclk(bclk), .cs_n(cs_n), .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef ADC_RX_OVERRUN_EN
    , .overrun(overrun), .overrun_clr(overrun_clr)
`endif
  );

  adc_rx dut_def (
    .clk_48(clk_48), .reset_n(reset_n), .enable(enable_d), .sdata_l(sdata_l), .sdata_r(sdata_r),
    .bclk(bclk_d), .cs_n(cs_n_d), .left_out(left_d), .right_out(right_d),
    .out_valid(out_valid_d), .out_ready(1'b1), .busy(busy_d)
`ifdef ADC_RX_OVERRUN_EN
    , .overrun(overrun_d), .overrun_clr(1'b0)
`endif
  );

  // ADC model: moves to the next bit on every bclk falling edge inside the cs_n window.
  always @(negedge bclk) begin
    #1;
    if (!cs_n && idx < 16) begin
      if (idx == 0) begin
        cur_l = tx_l;
        cur_r = tx_r;
      end
      sdata_l = cur_l[15-idx];
      sdata_r = cur_r[15-idx];
      idx++;
    end else if (cs_n) idx = 0;
  end

  task automatic test_reset;
    @(negedge clk_48);
    total++; if (bclk !== 1'b0) $display("FAIL reset_bclk: got %b expected 0", bclk); else passed++;
    total++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b expected 1", cs_n); else passed++;
    total++; if (left_out !== 16'h0) $display("FAIL reset_left: got %h expected 0000", left_out); else passed++;
    total++; if (right_out !== 16'h0) $display("FAIL reset_right: got %h expected 0000", right_out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
`ifdef ADC_RX_OVERRUN_EN
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
`endif
  endtask

  task automatic test_capture;
    int n, low, busy_bad;
    tx_l = 16'h8001; tx_r = 16'h7FFE; out_ready = 1'b1; enable = 1'b1;
    reset_n = 1'b1;
    n = 0;
    while (cs_n && n < 200) begin @(negedge clk_48); n++; end
    low = 0; busy_bad = 0;
    while (!cs_n && low < 200) begin
      if (busy !== 1'b1) busy_bad++;
      low++;
      @(negedge clk_48);
    end
    total++; if (low != 64) $display("FAIL cs_low_window: got %0d cycles expected 64", low); else passed++;
    total++; if (busy_bad != 0) $display("FAIL busy_in_shift: got %0d low samples expected 0", busy_bad); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL cap_valid: got %b expected 1", out_valid); else passed++;
    total++; if (left_out !== 16'h8001) $display("FAIL cap_left: got %h expected 8001", left_out); else passed++;
    total++; if (right_out !== 16'h7FFE) $display("FAIL cap_right: got %h expected 7ffe", right_out); else passed++;
  endtask

  task automatic test_continuous;
    int n, hi, run, glitch;
    logic prev, started;
    tx_l = 16'h1357; tx_r = 16'h2468;
    @(negedge clk_48);
    total++; if (out_valid !== 1'b0) $display("FAIL valid_pulse_once: got %b expected 0", out_valid); else passed++;
    n = 1; hi = int'(bclk); prev = bclk; run = 1; started = 1'b0; glitch = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk_48);
      n++;
      if (bclk === prev) run++;
      else begin
        if (started && run != 2) glitch++;
        started = 1'b1; prev = bclk; run = 1;
      end
      hi += int'(bclk);
    end
    total++; if (n != 80) $display("FAIL frame_period: got %0d cycles expected 80", n); else passed++;
    total++; if (glitch != 0) $display("FAIL bclk_runs: got %0d bad half-periods expected 0", glitch); else passed++;
    total++; if (hi != 40) $display("FAIL bclk_duty: got %0d high cycles expected 40", hi); else passed++;
    total++; if (left_out !== 16'h1357) $display("FAIL cont_left: got %h expected 1357", left_out); else passed++;
    total++; if (right_out !== 16'h2468) $display("FAIL cont_right: got %h expected 2468", right_out); else passed++;
  endtask

  task automatic test_stall;
    int n;
    out_ready = 1'b0;
    tx_l = 16'hAAAA; tx_r = 16'h5555;
    n = 0;
    while (cs_n && n < 200) begin @(negedge clk_48); n++; end
    while (!cs_n && n < 200) begin @(negedge clk_48); n++; end
    total++; if (n >= 200) $display("FAIL stall_wait: got %0d cycles expected <200", n); else passed++;
    total++; if (left_out !== 16'h1357) $display("FAIL stall_left: got %h expected 1357", left_out); else passed++;
    total++; if (right_out !== 16'h2468) $display("FAIL stall_right: got %h expected 2468", right_out); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b expected 1", out_valid); else passed++;
`ifdef ADC_RX_OVERRUN_EN
    total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else passed++;
`endif
    out_ready = 1'b1;
    @(negedge clk_48);
    total++; if (out_valid !== 1'b0) $display("FAIL stall_transfer: got %b expected 0", out_valid); else passed++;
`ifdef ADC_RX_OVERRUN_EN
    total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else passed++;
    overrun_clr = 1'b1;
    @(negedge clk_48);
    overrun_clr = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL overrun_clr: got %b expected 0", overrun); else passed++;
`endif
  endtask

  task automatic test_enable_drop;
    int n;
    tx_l = 16'h0F0F; tx_r = 16'hF0F0;
    @(negedge clk_48);
    enable = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk_48); n++; end
    total++; if (out_valid !== 1'b1) $display("FAIL drop_valid: got %b expected 1", out_valid); else passed++;
    total++; if (left_out !== 16'h0F0F) $display("FAIL drop_left: got %h expected 0f0f", left_out); else passed++;
    total++; if (right_out !== 16'hF0F0) $display("FAIL drop_right: got %h expected f0f0", right_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy); else passed++;
    repeat (20) @(negedge clk_48);
    total++; if (bclk !== 1'b0) $display("FAIL idle_bclk: got %b expected 0", bclk); else passed++;
    total++; if (cs_n !== 1'b1) $display("FAIL idle_cs_n: got %b expected 1", cs_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    tx_l = 16'h5A5A; tx_r = 16'hA5A5; out_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk_48); n++; end
    total++; if (left_out !== 16'h5A5A) $display("FAIL pre_reset_left: got %h expected 5a5a", left_out); else passed++;
    tx_l = 16'h1234; tx_r = 16'hEDCB;
    n = 0;
    while (cs_n && n < 200) begin @(negedge clk_48); n++; end
    repeat (28) @(negedge clk_48);
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", out_valid); else passed++;
    total++; if (left_out !== 16'h0) $display("FAIL mid_reset_left: got %h expected 0000", left_out); else passed++;
    total++; if (right_out !== 16'h0) $display("FAIL mid_reset_right: got %h expected 0000", right_out); else passed++;
    total++; if (cs_n !== 1'b1) $display("FAIL mid_reset_cs_n: got %b expected 1", cs_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else passed++;
    @(negedge clk_48);
    reset_n = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk_48); n++; end
    total++; if (left_out !== 16'h1234) $display("FAIL post_reset_left: got %h expected 1234", left_out); else passed++;
    total++; if (right_out !== 16'hEDCB) $display("FAIL post_reset_right: got %h expected edcb", right_out); else passed++;
    enable = 1'b0;
  endtask

  task automatic test_default_frame;
    int n, low, per;
    enable_d = 1'b1;
    n = 0;
    while (cs_n_d && n < 2000) begin @(negedge clk_48); n++; end
    low = 0;
    while (!cs_n_d && low < 2000) begin low++; @(negedge clk_48); end
    per = low;
    while (cs_n_d && per < 3000) begin per++; @(negedge clk_48); end
    total++; if (low != 64) $display("FAIL default_cs_window: got %0d cycles expected 64", low); else passed++;
    total++; if (per != 1000) $display("FAIL default_frame: got %0d cycles expected 1000", per); else passed++;
  endtask

  initial begin
    test_reset;
    test_capture;
    test_continuous;
    test_stall;
    test_enable_drop;
    test_reset_mid;
    test_default_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
